seg_scan_ctrl: RTL and testbench



---
 rtl/seg_pkg.sv | 13 +
 rtl/seg_scan_ctrl_if.sv | 27 ++
 rtl/slot_timer.sv | 31 +++
 rtl/seg_scan_ctrl.sv | 173 +++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_ZERO = '0;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Load/ack data path and scan outputs between the BCD stage, the scanner and the shared decoder.
interface seg_scan_ctrl_if
  import seg_pkg::*;
#(
  parameter int NDIG = 4
);

  logic                    en;
  logic                    ld;
  logic [BCD_W*NDIG-1:0]   din;
  logic                    ack;
  logic [BCD_W-1:0]        bcd;
  logic                    ben;
  logic [NDIG-1:0]         an;
  logic                    frm;

  modport master (
    output en, ld, din,
    input  ack, bcd, ben, an, frm
  );

  modport slave (
    input  en, ld, din,
    output ack, bcd, ben, an, frm
  );

endinterface

// File: rtl/slot_timer.sv
// Per-digit slot counter: flags the last visible cycle and the last cycle of each slot.
module slot_timer #(
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic slot_end,
  output logic blank_start
);

  localparam int CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] cnt_reg;

  assign slot_end    = (cnt_reg == CNT_W'(CLK_DIV - 1));
  assign blank_start = (cnt_reg == CNT_W'(CLK_DIV - BLANK_CYC - 1));

  // Held at zero whenever the scanner is idle so every slot starts from a clean count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (!run || slot_end) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed digit scanner with frame-synchronous shadow update feeding one shared BCD decoder.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NDIG      = 4,
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 500,
  parameter int LZB       = 1
) (
  input  logic            clk,
  input  logic            rst,
  seg_scan_ctrl_if.slave  bus
);

  localparam int IDX_W = $clog2(NDIG);

  state_t                 state_reg, state_next;
  logic [IDX_W-1:0]       idx_reg, idx_next;
  logic [BCD_W*NDIG-1:0]  shadow_reg, shadow_next;
  logic [BCD_W*NDIG-1:0]  pend_reg, pend_next;
  logic                   pend_flag_reg, pend_flag_next;
  logic                   ack_reg, ack_next;
  logic [BCD_W-1:0]       bcd_reg, bcd_next;
  logic                   ben_reg, ben_next;
  logic [NDIG-1:0]        an_reg, an_next;
  logic                   frm_reg, frm_next;

  logic                   run, slot_end, blank_start, boundary, commit;
  logic [BCD_W-1:0]       digit [NDIG];
  logic [NDIG-1:0]        lz_blank;

  assign run      = (state_reg != ST_IDLE) && bus.en;
  assign boundary = (state_reg == ST_BLANK) && slot_end && (idx_reg == IDX_W'(NDIG - 1));

  slot_timer #(
    .CLK_DIV   (CLK_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_slot_timer (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .slot_end    (slot_end),
    .blank_start (blank_start)
  );

  // Digits are taken from the post-commit shadow so a new frame shows new data from its first cycle.
  for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
    assign digit[gi] = shadow_next[gi*BCD_W +: BCD_W];
  end

  always_comb begin
    logic hz;
    lz_blank = '0;
    hz       = 1'b1;
    for (int i = NDIG - 1; i >= 1; i--) begin
      hz          = hz && (digit[i] == BCD_ZERO);
      lz_blank[i] = (LZB != 0) && hz;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      ST_IDLE: begin
        idx_next = '0;
        if (bus.en) state_next = ST_SHOW;
      end
      ST_SHOW: begin
        if (!bus.en) begin
          state_next = ST_IDLE;
          idx_next   = '0;
        end else if (blank_start) begin
          state_next = ST_BLANK;
        end
      end
      ST_BLANK: begin
        if (!bus.en) begin
          state_next = ST_IDLE;
          idx_next   = '0;
        end else if (slot_end) begin
          state_next = ST_SHOW;
          idx_next   = (idx_reg == IDX_W'(NDIG - 1)) ? '0 : idx_reg + 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        idx_next   = '0;
      end
    endcase
  end

  // Commit policy: immediate when stopped, otherwise deferred to the frame boundary (last ld wins).
  always_comb begin
    shadow_next    = shadow_reg;
    pend_next      = pend_reg;
    pend_flag_next = pend_flag_reg;
    commit         = 1'b0;
    if ((state_reg == ST_IDLE) || !bus.en) begin
      if (bus.ld) begin
        shadow_next    = bus.din;
        pend_flag_next = 1'b0;
        commit         = 1'b1;
      end else if ((state_reg == ST_IDLE) && pend_flag_reg) begin
        shadow_next    = pend_reg;
        pend_flag_next = 1'b0;
        commit         = 1'b1;
      end
    end else if (boundary) begin
      pend_flag_next = 1'b0;
      if (bus.ld) begin
        shadow_next = bus.din;
        commit      = 1'b1;
      end else if (pend_flag_reg) begin
        shadow_next = pend_reg;
        commit      = 1'b1;
      end
    end else if (bus.ld) begin
      pend_next      = bus.din;
      pend_flag_next = 1'b1;
    end
  end

  always_comb begin
    an_next  = '0;
    ben_next = 1'b0;
    bcd_next = bcd_reg;
    ack_next = commit;
    frm_next = boundary && bus.en;
    case (state_next)
      ST_IDLE:  bcd_next = BCD_ZERO;
      ST_SHOW: begin
        an_next[idx_next] = 1'b1;
        bcd_next          = digit[idx_next];
        ben_next          = !lz_blank[idx_next];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= '0;
      shadow_reg    <= '0;
      pend_reg      <= '0;
      pend_flag_reg <= 1'b0;
      ack_reg       <= 1'b0;
      bcd_reg       <= '0;
      ben_reg       <= 1'b0;
      an_reg        <= '0;
      frm_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      shadow_reg    <= shadow_next;
      pend_reg      <= pend_next;
      pend_flag_reg <= pend_flag_next;
      ack_reg       <= ack_next;
      bcd_reg       <= bcd_next;
      ben_reg       <= ben_next;
      an_reg        <= an_next;
      frm_reg       <= frm_next;
    end
  end

  assign bus.ack = ack_reg;
  assign bus.bcd = bcd_reg;
  assign bus.ben = ben_reg;
  assign bus.an  = an_reg;
  assign bus.frm = frm_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench: two scanners (LZB=0 and LZB=1) share the same stimulus; 2 digits, 16-cycle frame.
module tb_seg_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       en;
  logic       ld;
  logic [7:0] din;

  int total;
  int bad;

  seg_scan_ctrl_if #(.NDIG(2)) bus_a ();
  seg_scan_ctrl_if #(.NDIG(2)) bus_z ();

  assign bus_a.en  = en;
  assign bus_a.ld  = ld;
  assign bus_a.din = din;
  assign bus_z.en  = en;
  assign bus_z.ld  = ld;
  assign bus_z.din = din;

  seg_scan_ctrl #(.NDIG(2), .CLK_DIV(8), .BLANK_CYC(2), .LZB(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  seg_scan_ctrl #(.NDIG(2), .CLK_DIV(8), .BLANK_CYC(2), .LZB(1)) dut_lz (
    .clk (clk),
    .rst (rst),
    .bus (bus_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Checks positions from..to of a frame on the LZB=0 scanner; pos 0 also checks frm/ack.
  task automatic scan(input int from, input int to, input logic [3:0] d0, input logic [3:0] d1,
                      input logic f0, input logic a0);
    int         slot;
    int         pos;
    logic [1:0] ean;
    logic [3:0] ebcd;
    logic       eben;
    for (int c = from; c <= to; c++) begin
      slot = c / 8;
      pos  = c % 8;
      ebcd = (slot != 0) ? d1 : d0;
      if (pos < 6) begin
        ean  = (slot != 0) ? 2'b10 : 2'b01;
        eben = 1'b1;
      end else begin
        ean  = 2'b00;
        eben = 1'b0;
      end
      chk($sformatf("an@%0d", c), 32'(bus_a.an), 32'(ean));
      chk($sformatf("bcd@%0d", c), 32'(bus_a.bcd), 32'(ebcd));
      chk($sformatf("ben@%0d", c), 32'(bus_a.ben), 32'(eben));
      chk($sformatf("frm@%0d", c), 32'(bus_a.frm), (c == 0) ? 32'(f0) : 32'd0);
      chk($sformatf("ack@%0d", c), 32'(bus_a.ack), (c == 0) ? 32'(a0) : 32'd0);
      step(1);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    en    = 1'b0;
    ld    = 1'b0;
    din   = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    $display("reset state");
    chk("rst_an", 32'(bus_a.an), 32'd0);
    chk("rst_ben", 32'(bus_a.ben), 32'd0);
    chk("rst_bcd", 32'(bus_a.bcd), 32'd0);
    chk("rst_ack", 32'(bus_a.ack), 32'd0);
    chk("rst_frm", 32'(bus_a.frm), 32'd0);
    rst = 1'b0;
    step(1);
    chk("idle_an", 32'(bus_a.an), 32'd0);

    $display("load while idle and scan 25");
    ld  = 1'b1;
    din = 8'h25;
    step(1);
    ld  = 1'b0;
    chk("idle_ack", 32'(bus_a.ack), 32'd1);
    chk("idle_an2", 32'(bus_a.an), 32'd0);
    en = 1'b1;
    step(1);
    chk("idle_ack_clr", 32'(bus_a.ack), 32'd0);
    scan(0, 15, 4'h5, 4'h2, 1'b0, 1'b0);

    $display("tear-free commit of 34");
    scan(0, 1, 4'h5, 4'h2, 1'b1, 1'b0);
    ld  = 1'b1;
    din = 8'h34;
    scan(2, 2, 4'h5, 4'h2, 1'b0, 1'b0);
    ld  = 1'b0;
    scan(3, 15, 4'h5, 4'h2, 1'b0, 1'b0);
    scan(0, 15, 4'h4, 4'h3, 1'b1, 1'b1);

    $display("last-wins 11 then 99");
    scan(0, 2, 4'h4, 4'h3, 1'b1, 1'b0);
    ld  = 1'b1;
    din = 8'h11;
    scan(3, 3, 4'h4, 4'h3, 1'b0, 1'b0);
    ld  = 1'b0;
    scan(4, 9, 4'h4, 4'h3, 1'b0, 1'b0);
    ld  = 1'b1;
    din = 8'h99;
    scan(10, 10, 4'h4, 4'h3, 1'b0, 1'b0);
    ld  = 1'b0;
    scan(11, 15, 4'h4, 4'h3, 1'b0, 1'b0);
    scan(0, 15, 4'h9, 4'h9, 1'b1, 1'b1);

    $display("boundary ld 42 over pending 77");
    scan(0, 2, 4'h9, 4'h9, 1'b1, 1'b0);
    ld  = 1'b1;
    din = 8'h77;
    scan(3, 3, 4'h9, 4'h9, 1'b0, 1'b0);
    ld  = 1'b0;
    scan(4, 14, 4'h9, 4'h9, 1'b0, 1'b0);
    ld  = 1'b1;
    din = 8'h42;
    scan(15, 15, 4'h9, 4'h9, 1'b0, 1'b0);
    ld  = 1'b0;
    scan(0, 7, 4'h2, 4'h4, 1'b1, 1'b1);

    $display("enable drop during digit 1");
    scan(8, 9, 4'h2, 4'h4, 1'b0, 1'b0);
    en = 1'b0;
    step(1);
    chk("drop_an", 32'(bus_a.an), 32'd0);
    chk("drop_ben", 32'(bus_a.ben), 32'd0);
    chk("drop_bcd", 32'(bus_a.bcd), 32'd0);
    step(2);
    chk("drop_an2", 32'(bus_a.an), 32'd0);
    en = 1'b1;
    step(1);
    scan(0, 15, 4'h2, 4'h4, 1'b0, 1'b0);
    scan(0, 0, 4'h2, 4'h4, 1'b1, 1'b0);

    $display("pending 56 committed in idle");
    ld  = 1'b1;
    din = 8'h56;
    scan(1, 1, 4'h2, 4'h4, 1'b0, 1'b0);
    ld  = 1'b0;
    scan(2, 3, 4'h2, 4'h4, 1'b0, 1'b0);
    en = 1'b0;
    step(1);
    chk("pidle_an", 32'(bus_a.an), 32'd0);
    chk("pidle_ack0", 32'(bus_a.ack), 32'd0);
    step(1);
    chk("pidle_ack1", 32'(bus_a.ack), 32'd1);
    en = 1'b1;
    step(1);
    scan(0, 7, 4'h6, 4'h5, 1'b0, 1'b0);

    $display("async reset mid-show drops pending 34");
    ld  = 1'b1;
    din = 8'h34;
    scan(8, 8, 4'h6, 4'h5, 1'b0, 1'b0);
    ld  = 1'b0;
    scan(9, 10, 4'h6, 4'h5, 1'b0, 1'b0);
    chk("pre_rst_an", 32'(bus_a.an), 32'd2);
    #2;
    rst = 1'b1;
    en  = 1'b0;
    #1;
    chk("arst_an", 32'(bus_a.an), 32'd0);
    chk("arst_ben", 32'(bus_a.ben), 32'd0);
    chk("arst_bcd", 32'(bus_a.bcd), 32'd0);
    chk("arst_ack", 32'(bus_a.ack), 32'd0);
    chk("arst_frm", 32'(bus_a.frm), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(2);
    chk("post_rst_an", 32'(bus_a.an), 32'd0);
    chk("post_rst_ack", 32'(bus_a.ack), 32'd0);
    en = 1'b1;
    step(1);
    scan(0, 15, 4'h0, 4'h0, 1'b0, 1'b0);

    $display("leading-zero blanking");
    chk("lz00_an0", 32'(bus_z.an), 32'd1);
    chk("lz00_bcd0", 32'(bus_z.bcd), 32'd0);
    chk("lz00_ben0", 32'(bus_z.ben), 32'd1);
    step(8);
    chk("lz00_an1", 32'(bus_z.an), 32'd2);
    chk("lz00_ben1", 32'(bus_z.ben), 32'd0);
    en = 1'b0;
    step(1);
    ld  = 1'b1;
    din = 8'h07;
    step(1);
    ld  = 1'b0;
    chk("lz07_ack", 32'(bus_z.ack), 32'd1);
    en = 1'b1;
    step(1);
    chk("lz07_an0", 32'(bus_z.an), 32'd1);
    chk("lz07_bcd0", 32'(bus_z.bcd), 32'd7);
    chk("lz07_ben0", 32'(bus_z.ben), 32'd1);
    step(8);
    chk("lz07_an1", 32'(bus_z.an), 32'd2);
    chk("lz07_bcd1", 32'(bus_z.bcd), 32'd0);
    chk("lz07_ben1", 32'(bus_z.ben), 32'd0);
    chk("nolz07_ben1", 32'(bus_a.ben), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
